// File: rtl/local_packet_receiver_pkg.sv
// Shared types and constants for the local packet receiver.
// Holds the flit/packet geometry and the receive FSM state encoding.
package local_packet_receiver_pkg;

  localparam int FLIT_SIZE        = 4;
  localparam int PACKET_SIZE      = 32;
  localparam int FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;
  localparam int FLIT_CNT_W       = $clog2(FLITS_PER_PACKET);

  typedef logic [FLIT_SIZE-1:0]   flit_t;
  typedef logic [PACKET_SIZE-1:0] packet_t;

  // Receive FSM: waiting for a header nibble, or mid-packet
  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

endpackage

// File: rtl/local_packet_receiver_if.sv
// Router-to-neuron link bundle: flit input side with backpressure, plus the
// packet valid/ready output side toward the neuron core.
// slave  = the receiver; master = the environment (router + neuron core).
interface local_packet_receiver_if;

  local_packet_receiver_pkg::flit_t   flit_in;
  logic                               write_req;
  logic                               full;
  local_packet_receiver_pkg::packet_t packet_out;
  logic                               packet_valid;
  logic                               packet_ready;

  modport master (
    output flit_in, write_req, packet_ready,
    input  full, packet_out, packet_valid
  );

  modport slave (
    input  flit_in, write_req, packet_ready,
    output full, packet_out, packet_valid
  );

endinterface

// File: rtl/local_packet_receiver_packet_sync_fifo.sv
// Single-clock first-word-fall-through FIFO for complete packets.
// data_o shows the head entry whenever the FIFO is non-empty and reads 0 when
// empty. Pushes while full are ignored; pops while empty are ignored.
module packet_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Occupancy update; simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally as DEPTH is a power of 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage write; contents need no reset since data_o is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/local_packet_receiver.sv
// Neuron-side receiver on the router local output. Collects 4-bit flits
// (header nibble first) into 32-bit packets, buffers complete packets in a
// small FIFO and hands them to the neuron core over valid/ready.
// Optional feature macro: LOCAL_RX_STATS_EN adds saturating packet/drop counters.
module local_packet_receiver
  import local_packet_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  local_packet_receiver_if.slave link,
  output logic                  drop_flag
`ifdef LOCAL_RX_STATS_EN
  ,
  output logic [15:0]           rx_packet_count,
  output logic [15:0]           rx_drop_count
`endif
);

  localparam int ASM_W = PACKET_SIZE - FLIT_SIZE;

  rx_state_e               state_q;
  logic [FLIT_CNT_W-1:0]   cnt_q;
  logic [ASM_W-1:0]        asm_q;
  logic                    drop_flag_q;

  logic                    fifo_full;
  logic                    fifo_valid;
  packet_t                 fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic                    accept;
  logic                    drop;
  logic                    last_flit;
  packet_t                 push_data;

  // Backpressure depends only on stored occupancy, never on write_req
  assign accept    = link.write_req & ~fifo_full;
  assign drop      = link.write_req & fifo_full;
  assign last_flit = accept && (state_q == RX_RECV) &&
                     (cnt_q == FLIT_CNT_W'(FLITS_PER_PACKET - 1));
  assign push_data = {asm_q, link.flit_in};

  // Receive FSM: shift accepted flits in, count them, release on the 8th
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else if (accept) begin
      asm_q <= {asm_q[ASM_W-FLIT_SIZE-1:0], link.flit_in};
      case (state_q)
        RX_IDLE: begin
          state_q <= RX_RECV;
          cnt_q   <= FLIT_CNT_W'(1);
        end
        RX_RECV: begin
          if (last_flit) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RX_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Sticky indication that a flit was lost to backpressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    drop_flag_q <= 1'b0;
    else if (drop) drop_flag_q <= 1'b1;
  end

  assign drop_flag = drop_flag_q;

  packet_sync_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (last_flit),
    .push_data_i (push_data),
    .pop_i       (link.packet_ready),
    .data_o      (fifo_data),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign link.full         = fifo_full;
  assign link.packet_valid = fifo_valid;
  assign link.packet_out   = fifo_data;

`ifdef LOCAL_RX_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;

  // Saturating counters of pushed packets and dropped flits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (last_flit && pkt_cnt_q != 16'hFFFF)  pkt_cnt_q  <= pkt_cnt_q + 1'b1;
      if (drop && drop_cnt_q != 16'hFFFF)      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign rx_packet_count = pkt_cnt_q;
  assign rx_drop_count   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_local_packet_receiver.sv
// Directed bench for local_packet_receiver: consecutive and gapped packets,
// FIFO fill/drop/pop behaviour, simultaneous push+pop, and mid-packet reset.
module tb_local_packet_receiver;
  import local_packet_receiver_pkg::*;

  logic clk;
  logic reset;
  logic drop_flag;
`ifdef LOCAL_RX_STATS_EN
  logic [15:0] rx_packet_count;
  logic [15:0] rx_drop_count;
`endif

  int checks = 0;
  int errors = 0;

  local_packet_receiver_if lprx_if ();

  local_packet_receiver #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .link            (lprx_if),
    .drop_flag       (drop_flag)
`ifdef LOCAL_RX_STATS_EN
    ,
    .rx_packet_count (rx_packet_count),
    .rx_drop_count   (rx_drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one flit for exactly one clock edge, then sample 1 time unit later
  task automatic send_flit(input logic [3:0] f);
    lprx_if.flit_in   = f;
    lprx_if.write_req = 1'b1;
    @(posedge clk);
    #1;
    lprx_if.write_req = 1'b0;
  endtask

  // Send flits [first..last] of a packet (index 0 = header nibble)
  task automatic send_range(input logic [31:0] p, input int first, input int last);
    logic [31:0] v;
    v = p;
    for (int i = first; i <= last; i++) send_flit(v[31-4*i -: 4]);
  endtask

  task automatic send_packet(input logic [31:0] p);
    send_range(p, 0, 7);
    $display("packet sent %h", p);
  endtask

  task automatic pop_one();
    $display("packet popped %h", lprx_if.packet_out);
    lprx_if.packet_ready = 1'b1;
    @(posedge clk);
    #1;
    lprx_if.packet_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset                = 1'b0;
    lprx_if.flit_in      = '0;
    lprx_if.write_req    = 1'b0;
    lprx_if.packet_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_full",  lprx_if.full,         0);
    check("rst_valid", lprx_if.packet_valid, 0);
    check("rst_out",   lprx_if.packet_out,   0);
    check("rst_drop",  drop_flag,            0);
    @(negedge clk);
    reset = 1'b1;

    // Consecutive packet 12345678
    send_range(32'h12345678, 0, 6);
    check("c7_valid", lprx_if.packet_valid, 0);
    send_range(32'h12345678, 7, 7);
    $display("packet sent %h", 32'h12345678);
    check("c8_valid", lprx_if.packet_valid, 1);
    check("c8_out",   lprx_if.packet_out,   32'h12345678);
    check("c8_state", dut.state_q,          RX_IDLE);
    pop_one();
    check("c_pop_valid", lprx_if.packet_valid, 0);
    check("c_pop_out",   lprx_if.packet_out,   0);

    // Same packet with a 3-cycle gap after the 4th flit
    send_range(32'h12345678, 0, 3);
    for (int g = 0; g < 3; g++) begin
      @(posedge clk);
      #1;
      check("gap_state", dut.state_q, RX_RECV);
      check("gap_cnt",   dut.cnt_q,   4);
      check("gap_valid", lprx_if.packet_valid, 0);
    end
    send_range(32'h12345678, 4, 7);
    $display("packet sent %h (gapped)", 32'h12345678);
    check("gap_out",   lprx_if.packet_out,   32'h12345678);
    check("gap_valid_end", lprx_if.packet_valid, 1);
    pop_one();

    // Fill the FIFO with the consumer stalled
    send_packet(32'hA0000001);
    send_packet(32'hA0000002);
    send_packet(32'hA0000003);
    check("fill3_full", lprx_if.full, 0);
    send_packet(32'hA0000004);
    check("fill4_full", lprx_if.full, 1);
    check("fill4_out",  lprx_if.packet_out, 32'hA0000001);
    send_flit(4'h9);
    $display("flit 9 offered while full");
    check("drop_flag",  drop_flag, 1);
    check("drop_state", dut.state_q, RX_IDLE);
    check("drop_cnt",   dut.cnt_q, 0);
    check("drop_count", dut.u_fifo.count_q, 4);
    check("drop_out",   lprx_if.packet_out, 32'hA0000001);
`ifdef LOCAL_RX_STATS_EN
    check("stat_pkts",  rx_packet_count, 6);
    check("stat_drops", rx_drop_count,   1);
`endif

    // Single pop from full
    pop_one();
    check("pop1_full",  lprx_if.full, 0);
    check("pop1_out",   lprx_if.packet_out, 32'hA0000002);
    check("pop1_count", dut.u_fifo.count_q, 3);

    // Complete a packet on the same edge as a pop: count unchanged
    send_range(32'hA0000005, 0, 6);
    lprx_if.packet_ready = 1'b1;
    send_range(32'hA0000005, 7, 7);
    lprx_if.packet_ready = 1'b0;
    $display("packet sent %h with simultaneous pop", 32'hA0000005);
    check("pp_count", dut.u_fifo.count_q, 3);
    check("pp_out",   lprx_if.packet_out, 32'hA0000003);
    send_packet(32'hA0000006);
    check("pp_full",  lprx_if.full, 1);

    // Drain in order
    check("drain_a3", lprx_if.packet_out, 32'hA0000003);
    pop_one();
    check("drain_a4", lprx_if.packet_out, 32'hA0000004);
    pop_one();
    check("drain_a5", lprx_if.packet_out, 32'hA0000005);
    pop_one();
    check("drain_a6", lprx_if.packet_out, 32'hA0000006);
    pop_one();
    check("drain_valid", lprx_if.packet_valid, 0);

    // Reset in the middle of a packet
    send_range(32'h12345678, 0, 4);
    check("mid_state", dut.state_q, RX_RECV);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", dut.state_q, RX_IDLE);
    check("arst_cnt",   dut.cnt_q,   0);
    check("arst_drop",  drop_flag,   0);
    check("arst_full",  lprx_if.full, 0);
`ifdef LOCAL_RX_STATS_EN
    check("arst_pkts",  rx_packet_count, 0);
    check("arst_drops", rx_drop_count,   0);
`endif
    @(negedge clk);
    reset = 1'b1;
    send_packet(32'hDEADBEEF);
    check("post_valid", lprx_if.packet_valid, 1);
    check("post_out",   lprx_if.packet_out,   32'hDEADBEEF);
    check("post_count", dut.u_fifo.count_q,   1);
    pop_one();
    check("post_empty", lprx_if.packet_valid, 0);
`ifdef LOCAL_RX_STATS_EN
    check("post_pkts",  rx_packet_count, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
